// File: rtl/proc_block_sink.sv
// rtl/proc_block_sink.sv - blocked-burst W sink: FIFO buffer, sequential processor-memory writes, block_fin handshake
//
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   routers_ps                    router present state (3'b001 = BLOCKED)
//   s_wvalid/s_wdata/s_wlast      diverted W beat in; s_wready out
//   mem_wr_en/addr/data           sequential memory write request; mem_ready in
//   proc_full                     back-pressure to router (registered occupancy based)
//   block_fin, block_ack          burst-written level and its acknowledge
//   blk_beats                     beats accepted in the current/last burst, saturating at 256
module proc_block_sink #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter int FULL_MARGIN = 1,
    parameter logic [ADDR_WIDTH-1:0] BLOCK_BASE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            routers_ps,
    input  logic                  s_wvalid,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic                  s_wlast,
    output logic                  s_wready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_ready,
    output logic                  proc_full,
    output logic                  block_fin,
    input  logic                  block_ack,
    output logic [8:0]            blk_beats
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESHOLD = CW'(DEPTH - FULL_MARGIN);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, FIN} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] fifo [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count, count_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [8:0]            beats;
    logic                  blocked, accept_ok, wr_req, push, pop, active;

    assign blocked = (routers_ps == 3'b001);

    // Acceptance and write request both use the registered count, so a pop
    // only frees a slot for the following cycle and a push only becomes
    // visible to memory one cycle later.
    always_comb begin
        active    = (state == COLLECT) || (state == DRAIN);
        accept_ok = (state == COLLECT) && blocked && (count < FULL_LVL);
        wr_req    = active && (count != '0);
        push      = s_wvalid && accept_ok;
        pop       = wr_req && mem_ready;
        count_nxt = count + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (blocked && s_wvalid) state_nxt = COLLECT;
            COLLECT: if (push && s_wlast)     state_nxt = DRAIN;
            // Enter FIN in the cycle right after the last write lands.
            DRAIN:   if (count_nxt == '0)     state_nxt = FIN;
            FIN:     if (block_ack)           state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low while rst is high so a reset mid-burst is
    // visible on the pins immediately.
    always_comb begin
        s_wready    = !rst && accept_ok;
        mem_wr_en   = !rst && wr_req;
        mem_wr_addr = mem_wr_en ? wr_addr : '0;
        mem_wr_data = mem_wr_en ? fifo[rd_ptr] : '0;
        proc_full   = !rst && active && (count >= THRESHOLD);
        block_fin   = !rst && (state == FIN);
        blk_beats   = rst ? 9'd0 : beats;
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo[wr_ptr] <= s_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            wr_addr <= BLOCK_BASE;
            beats   <= 9'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // A new burst always restarts at the base address; otherwise the
            // address advances with each completed write and wraps silently.
            if ((state == IDLE) && (state_nxt == COLLECT)) begin
                wr_addr <= BLOCK_BASE;
                beats   <= 9'd0;
            end else begin
                if (pop) begin
                    wr_addr <= wr_addr + ADDR_WIDTH'(1);
                end
                if (push && (beats != 9'd256)) begin
                    beats <= beats + 9'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_proc_block_sink.sv
// tb/tb_proc_block_sink.sv - self-checking bench for proc_block_sink (base 0 and base FE instances)
module tb_proc_block_sink;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int DEPTH = 8;
    localparam int FM = 1;
    localparam logic [AW-1:0] B0 = 8'h00;
    localparam logic [AW-1:0] B1 = 8'hFE;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    routers_ps = 3'b000;
    logic          s_wvalid = 1'b0;
    logic [DW-1:0] s_wdata = '0;
    logic          s_wlast = 1'b0;
    logic          mem_ready = 1'b0;
    logic          block_ack = 1'b0;

    logic          wready0, wr_en0, full0, fin0, wready1, wr_en1, full1, fin1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic [8:0]    beats0, beats1;

    proc_block_sink #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .FULL_MARGIN(FM), .BLOCK_BASE(B0)) dut0 (
        .clk(clk), .rst(rst), .routers_ps(routers_ps), .s_wvalid(s_wvalid), .s_wdata(s_wdata),
        .s_wlast(s_wlast), .s_wready(wready0), .mem_wr_en(wr_en0), .mem_wr_addr(addr0),
        .mem_wr_data(data0), .mem_ready(mem_ready), .proc_full(full0), .block_fin(fin0),
        .block_ack(block_ack), .blk_beats(beats0));

    proc_block_sink #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .FULL_MARGIN(FM), .BLOCK_BASE(B1)) dut1 (
        .clk(clk), .rst(rst), .routers_ps(routers_ps), .s_wvalid(s_wvalid), .s_wdata(s_wdata),
        .s_wlast(s_wlast), .s_wready(wready1), .mem_wr_en(wr_en1), .mem_wr_addr(addr1),
        .mem_wr_data(data1), .mem_ready(mem_ready), .proc_full(full1), .block_fin(fin1),
        .block_ack(block_ack), .blk_beats(beats1));

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_pct = 100;
    int sent_cnt = 0;

    // Reference model: phase 0 idle, 1 collecting, 2 draining, 3 finished.
    int            m_phase = 0;
    logic [DW-1:0] m_q[$];
    int            m_beats = 0;
    int            m_writes = 0;

    logic [AW-1:0] log_a0[$], log_a1[$];
    logic [DW-1:0] log_d[$], sent_d[$];
    int            last_wr_cyc = 0, fin_cyc = 0;
    logic          fin_prev = 1'b0;

    always @(posedge clk) begin
        logic acc, wr;
        cyc++;
        if (rst) begin
            m_phase = 0; m_q.delete(); m_beats = 0; m_writes = 0;
        end else begin
            acc = s_wvalid && (m_phase == 1) && (routers_ps == 3'b001) && (m_q.size() < DEPTH);
            wr  = ((m_phase == 1) || (m_phase == 2)) && (m_q.size() != 0) && mem_ready;
            if (wr) begin void'(m_q.pop_front()); m_writes++; end
            if (acc) begin m_q.push_back(s_wdata); if (m_beats < 256) m_beats++; end
            case (m_phase)
                0: if ((routers_ps == 3'b001) && s_wvalid) begin m_phase = 1; m_beats = 0; m_writes = 0; end
                1: if (acc && s_wlast) m_phase = 2;
                2: if (m_q.size() == 0) m_phase = 3;
                default: if (block_ack) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic          ew, ee, ef, efin;
        logic [8:0]    eb;
        logic [DW-1:0] ed;
        logic [AW-1:0] ea0, ea1;
        if (rst) begin
            ew = 0; ee = 0; ef = 0; efin = 0; eb = 0; ed = '0; ea0 = '0; ea1 = '0;
        end else begin
            ew   = (m_phase == 1) && (routers_ps == 3'b001) && (m_q.size() < DEPTH);
            ee   = ((m_phase == 1) || (m_phase == 2)) && (m_q.size() != 0);
            ef   = ((m_phase == 1) || (m_phase == 2)) && (m_q.size() >= DEPTH - FM);
            efin = (m_phase == 3);
            eb   = 9'(m_beats);
            ed   = ee ? m_q[0] : '0;
            ea0  = B0 + AW'(m_writes);
            ea1  = B1 + AW'(m_writes);
        end
        vectors++;
        if ({wready0, wr_en0, full0, fin0, beats0} !== {ew, ee, ef, efin, eb}) begin
            errors++;
            $display("FAIL ctrl0 cyc=%0d got rdy/en/full/fin/beats=%b%b%b%b/%0d want %b%b%b%b/%0d",
                     cyc, wready0, wr_en0, full0, fin0, beats0, ew, ee, ef, efin, eb);
        end
        vectors++;
        if ({wready1, wr_en1, full1, fin1, beats1} !== {ew, ee, ef, efin, eb}) begin
            errors++;
            $display("FAIL ctrl1 cyc=%0d got %b%b%b%b/%0d want %b%b%b%b/%0d",
                     cyc, wready1, wr_en1, full1, fin1, beats1, ew, ee, ef, efin, eb);
        end
        if (ee) begin
            vectors++;
            if ({addr0, data0, addr1, data1} !== {ea0, ed, ea1, ed}) begin
                errors++;
                $display("FAIL wr cyc=%0d got a0=%h d0=%h a1=%h d1=%h want a0=%h a1=%h d=%h",
                         cyc, addr0, data0, addr1, data1, ea0, ea1, ed);
            end
        end
        if (wr_en0 && mem_ready) begin
            log_a0.push_back(addr0); log_d.push_back(data0); last_wr_cyc = cyc;
        end
        if (wr_en1 && mem_ready) log_a1.push_back(addr1);
        if (fin0 && !fin_prev) fin_cyc = cyc;
        fin_prev = fin0;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        mem_ready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic clear_logs();
        log_a0.delete(); log_a1.delete(); log_d.delete(); sent_d.delete(); sent_cnt = 0;
    endtask

    task automatic send_burst(input int n, input int gap_pct, input int drop_pct, input bit rnd, input bit with_last);
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] d;
            int guard = 0;
            bit done = 0;
            d = rnd ? DW'($urandom) : (32'hD000_0000 + DW'(i));
            while (!done) begin
                routers_ps = ($urandom_range(99) < drop_pct) ? 3'b000 : 3'b001;
                s_wvalid = !($urandom_range(99) < gap_pct);
                s_wdata = d;
                s_wlast = with_last && (i == n - 1);
                @(negedge clk);
                done = s_wvalid && wready0;
                tick();
                guard++;
                if (!done && guard > 500) begin
                    vectors++; errors++;
                    $display("FAIL send_timeout beat %0d accepted=%0d want %0d", i, sent_cnt, n);
                    s_wvalid = 0; s_wlast = 0; routers_ps = 3'b001;
                    return;
                end
            end
            sent_d.push_back(d);
            sent_cnt++;
        end
        s_wvalid = 0; s_wlast = 0; routers_ps = 3'b001;
    endtask

    task automatic wait_fin(input int max);
        int n = 0;
        @(negedge clk);
        while (!fin0 && n < max) begin
            tick(); @(negedge clk); n++;
        end
        vectors++;
        if (fin0 !== 1'b1) begin
            errors++;
            $display("FAIL fin_timeout got block_fin=%b want 1 within %0d cycles", fin0, max);
        end
    endtask

    task automatic do_ack();
        block_ack = 1; tick(); block_ack = 0;
    endtask

    task automatic test_reset();
        routers_ps = 3'b001; s_wvalid = 1;
        tick(); tick();
        @(negedge clk);
        vectors++;
        if ({wready0, wr_en0, addr0, data0, full0, fin0, beats0, wr_en1, addr1} !== '0) begin
            errors++;
            $display("FAIL reset_during got en=%b rdy=%b beats=%0d want all 0", wr_en0, wready0, beats0);
        end
        tick();
        rst = 0; s_wvalid = 0;
        @(negedge clk);
        vectors++;
        if ({wready0, wr_en0, addr0, data0, full0, fin0, beats0, wr_en1, addr1} !== '0) begin
            errors++;
            $display("FAIL reset_after got en=%b rdy=%b addr1=%h want all 0", wr_en0, wready0, addr1);
        end
    endtask

    task automatic test_basic();
        rdy_pct = 100; mem_ready = 1; clear_logs();
        send_burst(4, 0, 0, 0, 1);
        wait_fin(50);
        do_ack();
        vectors++;
        if (log_a0.size() != 4 || log_a1.size() != 4) begin
            errors++;
            $display("FAIL basic_count got %0d/%0d writes want 4", log_a0.size(), log_a1.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (log_a0[i] !== AW'(i) || log_d[i] !== 32'hD000_0000 + DW'(i) || log_a1[i] !== B1 + AW'(i)) begin
                    errors++;
                    $display("FAIL basic_write%0d got a0=%h d=%h a1=%h want a0=%h d=%h a1=%h", i,
                             log_a0[i], log_d[i], log_a1[i], AW'(i), 32'hD000_0000 + DW'(i), B1 + AW'(i));
                end
            end
        end
        vectors++;
        if (fin_cyc != last_wr_cyc + 1 || beats0 !== 9'd4) begin
            errors++;
            $display("FAIL basic_fin got fin_cyc=%0d beats=%0d want fin_cyc=%0d beats=4", fin_cyc, beats0, last_wr_cyc + 1);
        end
    endtask

    task automatic test_backpressure();
        rdy_pct = 0; mem_ready = 0; clear_logs();
        fork
            send_burst(10, 0, 0, 1, 1);
            begin
                repeat (20) @(negedge clk);
                vectors++;
                if (wready0 !== 1'b0 || full0 !== 1'b1 || sent_cnt != 8 || log_d.size() != 0) begin
                    errors++;
                    $display("FAIL bp_stall got rdy=%b full=%b accepted=%0d writes=%0d want 0 1 8 0",
                             wready0, full0, sent_cnt, log_d.size());
                end
                rdy_pct = 100;
            end
        join
        wait_fin(100);
        do_ack();
        vectors++;
        if (log_d.size() != 10) begin
            errors++;
            $display("FAIL bp_count got %0d writes want 10", log_d.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                vectors++;
                if (log_d[i] !== sent_d[i]) begin
                    errors++;
                    $display("FAIL bp_order beat %0d got %h want %h", i, log_d[i], sent_d[i]);
                end
            end
        end
    endtask

    task automatic test_ack_delay();
        rdy_pct = 100; clear_logs();
        send_burst(3, 0, 0, 1, 1);
        wait_fin(50);
        for (int i = 0; i < 5; i++) begin
            tick(); @(negedge clk);
            vectors++;
            if (fin0 !== 1'b1) begin
                errors++;
                $display("FAIL ack_hold cycle %0d got block_fin=%b want 1", i, fin0);
            end
        end
        block_ack = 1; tick(); block_ack = 0;
        @(negedge clk);
        vectors++;
        if (fin0 !== 1'b0) begin
            errors++;
            $display("FAIL ack_release got block_fin=%b want 0", fin0);
        end
        clear_logs();
        send_burst(2, 0, 0, 1, 1);
        wait_fin(50);
        do_ack();
        vectors++;
        if (log_a0.size() != 2 || log_a0[0] !== B0 || log_a1[0] !== B1 || log_a1[1] !== B1 + 8'd1) begin
            errors++;
            $display("FAIL ack_restart got %0d writes first a0=%h a1=%h want 2 %h %h", log_a0.size(),
                     (log_a0.size() > 0) ? log_a0[0] : 8'hxx, (log_a1.size() > 0) ? log_a1[0] : 8'hxx, B0, B1);
        end
    endtask

    task automatic test_router_drop();
        int n = 0;
        rdy_pct = 50; clear_logs();
        send_burst(3, 0, 0, 1, 0);
        routers_ps = 3'b000; s_wvalid = 1; s_wdata = DW'($urandom);
        @(negedge clk);
        vectors++;
        if (wready0 !== 1'b0) begin
            errors++;
            $display("FAIL drop_ready got s_wready=%b want 0", wready0);
        end
        while (wr_en0 && n < 100) begin tick(); @(negedge clk); n++; end
        vectors++;
        if (wr_en0 !== 1'b0 || fin0 !== 1'b0 || log_d.size() != 3) begin
            errors++;
            $display("FAIL drop_drain got en=%b fin=%b writes=%0d want 0 0 3", wr_en0, fin0, log_d.size());
        end
        tick();
        send_burst(2, 0, 0, 1, 1);
        wait_fin(100);
        do_ack();
        vectors++;
        if (log_d.size() != 5 || log_d[3] !== sent_d[3] || log_d[4] !== sent_d[4]) begin
            errors++;
            $display("FAIL drop_resume got %0d writes want 5 in order", log_d.size());
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 25; b++) begin
            int len;
            len = $urandom_range(20, 1);
            rdy_pct = $urandom_range(100, 20);
            clear_logs();
            send_burst(len, $urandom_range(40), $urandom_range(30), 1, 1);
            wait_fin(400);
            vectors++;
            if (log_d.size() != len || beats0 !== 9'(len)) begin
                errors++;
                $display("FAIL rand%0d_count got writes=%0d beats=%0d want %0d", b, log_d.size(), beats0, len);
            end else begin
                for (int i = 0; i < len; i++) begin
                    vectors++;
                    if (log_d[i] !== sent_d[i] || log_a0[i] !== AW'(i)) begin
                        errors++;
                        $display("FAIL rand%0d_beat%0d got a=%h d=%h want a=%h d=%h", b, i, log_a0[i], log_d[i], AW'(i), sent_d[i]);
                    end
                end
            end
            repeat ($urandom_range(3)) tick();
            do_ack();
        end
    endtask

    task automatic test_saturate();
        rdy_pct = 100; clear_logs();
        send_burst(260, 0, 0, 1, 1);
        wait_fin(100);
        vectors++;
        if (beats0 !== 9'd256 || log_d.size() != 260 || log_a0[259] !== AW'(259 % 256)) begin
            errors++;
            $display("FAIL saturate got beats=%0d writes=%0d want 256 260", beats0, log_d.size());
        end
        do_ack();
    endtask

    task automatic test_rst_drain();
        rdy_pct = 0; mem_ready = 0; clear_logs();
        send_burst(3, 0, 0, 1, 1);
        @(negedge clk);
        vectors++;
        if (wr_en0 !== 1'b1 || fin0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre got en=%b fin=%b want 1 0", wr_en0, fin0);
        end
        tick();
        rst = 1;
        @(negedge clk);
        tick();
        rst = 0; rdy_pct = 100; mem_ready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({wready0, wr_en0, addr0, data0, full0, fin0, beats0, wr_en1} !== '0) begin
                errors++;
                $display("FAIL rst_drain cycle %0d got en=%b fin=%b beats=%0d want all 0", i, wr_en0, fin0, beats0);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_ack_delay();
        test_router_drop();
        test_random();
        test_saturate();
        test_rst_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
